// File: rtl/pe_net_packetizer_if.sv
// pe_net_packetizer_if
// Bundles the PE-side and router-side handshake signals of one packetizer.
//   in_valid/in_ready/in_type/in_data : PE offers typed 24-bit words
//   out_valid/out_ready/out_data      : 32-bit packets toward the tree router
//   err_drop                          : pulse when a reserved-type word is dropped
// Modports:
//   master : the packetizer itself (drives in_ready, out_*, err_drop)
//   slave  : the surrounding PE/router (drives in_*, out_ready)
interface pe_net_packetizer_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        err_drop;

  modport master (
    input  in_valid, in_type, in_data, out_ready,
    output in_ready, out_valid, out_data, err_drop
  );

  modport slave (
    output in_valid, in_type, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_drop
  );
endinterface

// File: rtl/pe_net_packetizer.sv
// pe_net_packetizer
// Network interface between a PE and its leaf port on the NOC tree. Typed
// 24-bit words are stamped with src/dst addresses, buffered in a DEPTH-entry
// FIFO and presented to the router through a one-entry output register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : pe_net_packetizer_if.master (PE side, router side, err_drop)
//   pkt_count   : (PKT_STATS_EN only) 16-bit wrapping count of output handshakes
//   drop_count  : (PKT_STATS_EN only) 8-bit saturating count of dropped words
// Optional feature macro: PKT_STATS_EN
//
// Output register FSM:
//   state    | meaning
//   S_EMPTY  | output register empty, out_valid=0
//   S_LOADED | output register holds a packet, out_valid=1, out_data stable
module pe_net_packetizer #(
  parameter logic [2:0] SRC_ADDR = 3'b001,
  parameter logic [2:0] MEM_ADDR = 3'b000,
  parameter logic [2:0] ADD_ADDR = 3'b100,
  parameter int         DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pe_net_packetizer_if.master  bus
`ifdef PKT_STATS_EN
  ,
  output logic [15:0]          pkt_count,
  output logic [7:0]           drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_EMPTY, S_LOADED} state_t;

  state_t      state, state_nxt;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic        ready_en;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data_q;
  logic        err_drop_q;
  logic        accept, is_rsvd, push, pop, fifo_empty;
  logic [2:0]  dst;
  logic [31:0] pkt;

  // ready_en holds in_ready low during reset and for the edge of release.
  assign in_ready   = ready_en && (count != CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign accept     = bus.in_valid && in_ready;
  assign is_rsvd    = (bus.in_type == 2'b11);
  assign push       = accept && !is_rsvd;
  // Pop fills the output register when it is empty or being handed off.
  assign pop        = !fifo_empty && ((state == S_EMPTY) || bus.out_ready);

  always_comb begin
    dst = MEM_ADDR;
    case (bus.in_type)
      2'b00:   dst = ADD_ADDR;
      default: dst = MEM_ADDR;
    endcase
  end

  assign pkt = {dst, SRC_ADDR, bus.in_type, bus.in_data};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pkt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_drop_q <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      err_drop_q <= accept && is_rsvd;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY:  if (!fifo_empty) state_nxt = S_LOADED;
      S_LOADED: if (bus.out_ready && fifo_empty) state_nxt = S_EMPTY;
      default:  state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == S_LOADED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_data_q <= '0;
    else if (pop) out_data_q <= mem[rd_ptr];
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.err_drop  = err_drop_q;

`ifdef PKT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (out_valid && bus.out_ready) pkt_count <= pkt_count + 16'd1;
      if (err_drop_q && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_net_packetizer.sv
module tb_pe_net_packetizer;
  localparam int         DEPTH = 4;
  localparam logic [2:0] SRC   = 3'b001;
  localparam logic [2:0] MEM   = 3'b000;
  localparam logic [2:0] ADD   = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_net_packetizer_if ifc();
`ifdef PKT_STATS_EN
  logic [15:0] pkt_count;
  logic [7:0]  drop_count;
`endif

  pe_net_packetizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifc)
`ifdef PKT_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_pkt(input logic [1:0] t, input logic [23:0] d);
    logic [2:0] dst;
    dst = (t == 2'b00) ? ADD : MEM;
    return {dst, SRC, t, d};
  endfunction

  // Reference: queue of expected packets in accept order, plus counters.
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;
  bit          drop_exp = 1'b0;
  bit          hold_valid = 1'b0;
  logic [31:0] hold_data = '0;
  int          model_pkts = 0;
  int          model_drops = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("err_drop", 32'(ifc.err_drop), 32'(drop_exp));
      if (hold_valid) begin
        check("valid_held", 32'(ifc.out_valid), 32'd1);
        check("data_stable", ifc.out_data, hold_data);
      end
      hold_valid = ifc.out_valid && !ifc.out_ready;
      hold_data  = ifc.out_data;
      drop_exp   = ifc.in_valid && ifc.in_ready && (ifc.in_type == 2'b11);
      if (ifc.in_valid && ifc.in_ready) begin
        if (ifc.in_type != 2'b11) exp_q.push_back(model_pkt(ifc.in_type, ifc.in_data));
        else if (model_drops < 255) model_drops++;
      end
      if (ifc.out_valid && ifc.out_ready) begin
        model_pkts = (model_pkts + 1) % 65536;
        check("pkt_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("pkt_data", ifc.out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input logic [1:0] t, input logic [23:0] d,
                          input logic [31:0] exp);
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.in_type   = t;
    ifc.in_data   = d;
    check({tag, "_ready"}, 32'(ifc.in_ready), 32'd1);
    step();
    ifc.in_valid = 1'b0;
    check({tag, "_no_bypass"}, 32'(ifc.out_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(ifc.out_valid), 32'd1);
    check({tag, "_data"}, ifc.out_data, exp);
    step();
    check({tag, "_gone"}, 32'(ifc.out_valid), 32'd0);
  endtask

  initial begin
    int acc, drops, outs, sent, cyc;
    bit take;
    ifc.in_valid  = 1'b0;
    ifc.in_type   = 2'b00;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b0;

    // Reset values
    #12;
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_out_data", ifc.out_data, 32'd0);
    check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    check("rst_err_drop", 32'(ifc.err_drop), 32'd0);
    step();
    rst_n = 1'b1;
    check("rel_in_ready_low", 32'(ifc.in_ready), 32'd0);
    step();
    check("rel_in_ready_high", 32'(ifc.in_ready), 32'd1);
    mon_en = 1'b1;

    // Single words of each legal type
    send_one("psum", 2'b00, 24'h00ABCD, 32'h8400ABCD);
    send_one("mrd", 2'b01, 24'h000010, 32'h05000010);
    send_one("mwr", 2'b10, 24'h123456, 32'h06123456);

    // Reserved word between two psums
    ifc.out_ready = 1'b1;
    drops = 0; outs = 0;
    for (int i = 0; i < 10; i++) begin
      ifc.in_valid = (i < 3);
      ifc.in_type  = (i == 1) ? 2'b11 : 2'b00;
      ifc.in_data  = 24'h000200 + 24'(i);
      step();
      if (ifc.err_drop) drops++;
      if (ifc.out_valid && ifc.out_ready) outs++;
    end
    check("rsvd_drop_pulses", 32'(drops), 32'd1);
    check("rsvd_pkts_out", 32'(outs), 32'd2);
`ifdef PKT_STATS_EN
    check("rsvd_drop_count", 32'(drop_count), 32'd1);
`endif

    // Fill with router stalled: DEPTH+1 accepts
    ifc.out_ready = 1'b0;
    acc = 0;
    ifc.in_valid = 1'b1;
    ifc.in_type  = 2'b01;
    ifc.in_data  = 24'h000300;
    for (int c = 0; c < 12; c++) begin
      take = ifc.in_ready;
      step();
      if (take) begin
        acc++;
        ifc.in_type = 2'(acc % 3);
        ifc.in_data = 24'h000300 + 24'(acc);
      end
    end
    check("fill_accepts", 32'(acc), 32'(DEPTH + 1));
    check("fill_in_ready", 32'(ifc.in_ready), 32'd0);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 3; k++) begin
      check($sformatf("drain_valid_%0d", k), 32'(ifc.out_valid), 32'(k < DEPTH + 1));
      step();
    end

    // Random traffic with stalls on both sides
    sent = 0; cyc = 0;
    ifc.in_valid = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      if (!ifc.in_valid && ($urandom_range(0, 9) < 7)) begin
        ifc.in_valid = 1'b1;
        ifc.in_type  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        ifc.in_data  = 24'($urandom);
      end
      take = ifc.in_valid && ifc.in_ready;
      step();
      cyc++;
      if (take) begin
        sent++;
        ifc.in_valid = 1'b0;
      end
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (int c = 0; c < 50 && (exp_q.size() != 0 || ifc.out_valid); c++) step();
    check("rand_sent", 32'(sent), 32'd1000);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_idle", 32'(ifc.out_valid), 32'd0);
`ifdef PKT_STATS_EN
    check("pkt_count", 32'(pkt_count), 32'(model_pkts));
    check("drop_count", 32'(drop_count), 32'(model_drops));
`endif

    // Reset with packets buffered
    ifc.out_ready = 1'b0;
    ifc.in_type   = 2'b00;
    for (int i = 0; i < 4; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = 24'h000400 + 24'(i);
      step();
    end
    ifc.in_valid = 1'b0;
    check("pre_rst_valid", 32'(ifc.out_valid), 32'd1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("mid_rst_out_data", ifc.out_data, 32'd0);
    check("mid_rst_in_ready", 32'(ifc.in_ready), 32'd0);
    check("mid_rst_err_drop", 32'(ifc.err_drop), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    drop_exp = 1'b0;
    hold_valid = 1'b0;
    model_pkts = 0;
    model_drops = 0;
    ifc.out_ready = 1'b1;
    step();
    check("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);
    outs = 0;
    for (int i = 0; i < 5; i++) begin
      if (ifc.out_valid) outs++;
      step();
    end
    check("post_rst_no_valid", 32'(outs), 32'd0);
`ifdef PKT_STATS_EN
    check("post_rst_pkt_count", 32'(pkt_count), 32'd0);
`endif
    mon_en = 1'b1;
    send_one("post_rst", 2'b00, 24'h000055, 32'h84000055);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pe_net_packetizer.md
# pe_net_packetizer

Clocked network interface between a processing element (PE) and its leaf port on the NOC tree. It accepts typed 24-bit results or requests from the PE and buffers them in a small FIFO. Each entry is stamped with source and destination addresses to form a 32-bit packet, which is presented to the tree router's input port with a valid/ready handshake. One instance sits in front of each PE's `fromPE` port.

## Interface
- `SRC_ADDR`, default 3'b001: this PE's tree address, placed in bits [28:26].
- `MEM_ADDR`, default 3'b000: destination for memory request types.
- `ADD_ADDR`, default 3'b100: destination for partial-sum type.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  PE offers a word.
- `in_ready`  out  1  packetizer accepts the word this cycle.
- `in_type`  in  2  00 psum, 01 mem read, 10 mem write, 11 reserved.
- `in_data`  in  24  payload.
- `out_valid`  out  1  packet available to router.
- `out_ready`  in  1  router accepts packet this cycle.
- `out_data`  out  32  packet: [31:29] dst, [28:26] src, [25:24] type, [23:0] payload.
- `err_drop`  out  1  one-cycle pulse when a reserved-type word is discarded.

## Operation
- Transfer on either side occurs only on a cycle where valid and ready are both 1 at the rising edge.
- Destination decode happens at accept time:
  - type 00 maps to `ADD_ADDR`.
  - types 01 and 10 map to `MEM_ADDR`.
  - type 11 is accepted and discarded: not written to the FIFO, `err_drop` pulses the next cycle.
- Each stored entry holds the full 32-bit packet. Packet order out equals accept order.
- FIFO uses a write pointer, a read pointer and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- `in_ready` = (count != DEPTH). It is registered-state based, with no combinational path from `out_ready`. When full, a simultaneous pop does not enable a push in the same cycle.
- Output register FSM:
  - EMPTY: `out_valid`=0. Moves to LOADED when the FIFO is non-empty, popping the head into the output register.
  - LOADED: `out_valid`=1 and `out_data` is held stable.
  - On handshake in LOADED: if the FIFO is non-empty, reload from it and stay in LOADED (back-to-back, one packet per cycle). Otherwise go to EMPTY.
- Reset, including mid-transfer: FIFO is flushed, state goes to EMPTY, and `out_valid`=0, `out_data`=0, `in_ready`=0 while `rst_n` is low, `err_drop`=0. `in_ready` rises the first edge after deassertion. An in-flight packet is lost.

## Timing
- Latency: a word accepted at edge N with everything empty gives `out_valid`=1 after edge N+1.
- Sustained throughput: one packet per cycle when `out_ready` is held high.
- Total buffering is DEPTH FIFO entries plus 1 output register. With `out_ready`=0, DEPTH+1 words are accepted before `in_ready` falls.
- Simultaneous push and pop with a non-full FIFO: both occur and count is unchanged.
- A push into an empty FIFO while in EMPTY does not bypass the FIFO; the one-cycle latency always applies.
- `err_drop` is registered and is never asserted on two consecutive cycles unless reserved words are accepted on consecutive cycles.

## Configuration
- `PKT_STATS_EN`: when defined, adds output port `pkt_count` (16 bits). It increments on every output handshake, wraps 16'hFFFF to 0, and resets to 0.
- `PKT_STATS_EN` also adds `drop_count` (8 bits), which increments with each `err_drop` pulse and saturates at 8'hFF.
- When `PKT_STATS_EN` is undefined, neither port nor counter exists, and all other behaviour is identical.

## Test plan
- Reset, then one psum word with `in_data`=24'h00ABCD, `SRC_ADDR`=001, `out_ready`=1 -> one cycle later `out_valid`=1 and `out_data`=32'h8400ABCD.
- Mem read, `in_data`=24'h000010 -> `out_data`=32'h05000010; mem write -> bits [25:24]=10 and dst=000.
- `out_ready`=0, push continuously -> exactly DEPTH+1 (5) accepts, then `in_ready`=0. Raise `out_ready` -> 5 packets emerge in order on consecutive cycles, then `out_valid`=0.
- Reserved type 11 between two psums -> only 2 packets out, `err_drop` high for exactly one cycle, and `drop_count`=1 with `PKT_STATS_EN`.
- Random valid/ready stalls with 1000 words -> output sequence equals input sequence with no loss or duplication, and `out_data` stable whenever `out_valid`=1 and `out_ready`=0.
- Assert `rst_n`=0 with 3 packets buffered and `out_valid`=1 -> outputs go to 0 immediately. After release, `out_valid` stays 0 until new input, and `pkt_count`=0.
